// File: rtl/f2c_arb_pkg.sv
// Shared types and constants for the FPGA->CPU stream arbiter.
package f2c_arb_pkg;

  localparam int CHAN_WIDTH = 7;
  localparam logic [CHAN_WIDTH-1:0] F2C_ARB_CTRL = 7'h10;

  // Source index width covers the largest supported source count (8).
  localparam int SRC_IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef logic [SRC_IDX_W-1:0] src_idx_t;
  typedef logic [7:0]           burst_len_t;

  localparam burst_len_t BURST_LEN_RST = 8'd16;

  // Cyclic successor of a source index.
  function automatic src_idx_t next_idx(src_idx_t idx, int num_src);
    return (int'(idx) == num_src - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Cyclic priority encoder: first set request bit at or after ptr, wrapping.
module rr_arb_pick
  import f2c_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  src_idx_t           ptr,
  output logic               any,
  output src_idx_t           idx
);

  // Scan offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (req[j] && ((int'(ptr) + off) % NUM_SRC == j)) idx = src_idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/f2c_stream_arbiter.sv
// Round-robin, burst-granular arbiter sharing the f2c DMA stream between sources.
//
// state | meaning
// IDLE  | no grant held; arbitrate among enabled, valid sources
// GRANT | gnt source owns the stream; data/valid/ready pass through combinationally
module f2c_stream_arbiter
  import f2c_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    pcieClk_in,
  input  logic                    pcieRstN_in,
  input  logic [CHAN_WIDTH-1:0]   cpuChan_in,
  input  logic [31:0]             cpuWrData_in,
  input  logic                    cpuWrValid_in,
  output logic [31:0]             status_out,
  input  logic [NUM_SRC*64-1:0]   srcData_in,
  input  logic [NUM_SRC-1:0]      srcValid_in,
  output logic [NUM_SRC-1:0]      srcReady_out,
  output logic [63:0]             f2cData_out,
  output logic                    f2cValid_out,
  input  logic                    f2cReady_in,
  input  logic                    f2cReset_in
);

  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  src_idx_t           gnt_q, gnt_d;
  src_idx_t           rr_ptr_q, rr_ptr_d;
  burst_len_t         beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [NUM_SRC-1:0] en_mask_q, en_mask_d;
  burst_len_t         burst_len_q, burst_len_d;

  logic        pick_any;
  src_idx_t    pick_idx;
  logic        gnt_valid;
  logic        gnt_en;
  logic [63:0] gnt_data;
  logic        cfg_wr;
  logic        beat;
  logic        burst_done;
  logic        idle_done;
  logic        release_gnt;
  logic        unused_wr_bits;

  assign unused_wr_bits = ^{cpuWrData_in[31:24], cpuWrData_in[15:NUM_SRC]};

  rr_arb_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req (srcValid_in & en_mask_q),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Select the granted source's valid, enable bit and data.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_en    = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_q == src_idx_t'(i)) begin
        gnt_valid = srcValid_in[i];
        gnt_en    = en_mask_q[i];
        gnt_data  = srcData_in[i*64 +: 64];
      end
    end
  end

  assign cfg_wr = cpuWrValid_in && (cpuChan_in == F2C_ARB_CTRL);
  assign beat   = (state_q == GRANT) && gnt_valid && f2cReady_in;
  // >= rather than == so a burst length lowered below the running count ends on the next beat.
  assign burst_done  = beat && (burst_len_q != 8'd0) && (beat_cnt_q >= burst_len_q - 8'd1);
  assign idle_done   = !gnt_valid && (idle_cnt_q == IDLE_LAST);
  assign release_gnt = burst_done || !gnt_en || idle_done;

  // State and register update; async reset restores default config.
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      en_mask_q   <= '1;
      burst_len_q <= BURST_LEN_RST;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      en_mask_q   <= en_mask_d;
      burst_len_q <= burst_len_d;
    end
  end

  // Next-state, counters and config; the stream flush overrides arbitration but keeps config.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    en_mask_d   = en_mask_q;
    burst_len_d = burst_len_q;

    if (cfg_wr) begin
      en_mask_d   = cpuWrData_in[NUM_SRC-1:0];
      burst_len_d = cpuWrData_in[23:16];
    end

    if (f2cReset_in) begin
      state_d    = IDLE;
      rr_ptr_d   = '0;
      beat_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_d    = GRANT;
            gnt_d      = pick_idx;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            idle_cnt_d = '0;
          end else if (!gnt_valid && (idle_cnt_q != IDLE_LAST)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
          if (release_gnt) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(gnt_q, NUM_SRC);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output mux: pass-through only while granted and not flushing.
  always_comb begin
    f2cData_out  = '0;
    f2cValid_out = 1'b0;
    srcReady_out = '0;
    if ((state_q == GRANT) && !f2cReset_in) begin
      f2cData_out  = gnt_data;
      f2cValid_out = gnt_valid;
      for (int i = 0; i < NUM_SRC; i++) begin
        srcReady_out[i] = (gnt_q == src_idx_t'(i)) && f2cReady_in;
      end
    end
  end

  assign status_out = {8'(state_q), 8'(gnt_q), beat_cnt_q, 8'(en_mask_q)};

endmodule
